suspi_rx_mc: RTL and testbench
==============================

# suspi_rx_mc

Multi-channel, parametrised receiver for SUSPI asynchronous serial frames: start bit, DATA_W data bits LSB first, optional parity bit, stop bit. It deserialises CHANNELS independent command lines (COM1, COM2, …) with 3-sample majority voting at mid-bit. It checks parity (odd, even or none, selectable at runtime) and framing, and merges the received words into one valid/ready stream tagged with channel number and error flags. It sits between the external COM pins and the command-packet decoder, which assembles the marker/flag/length/CRC fields from this stream.

## Interface
Parameters:
- CHANNELS, default 2: number of serial input lines.
- DATA_W, default 8: data bits per frame.
- CLKS_PER_BIT, default 12: bb_clk_in cycles per bit (12 MHz clock, 1 Mbit/s). Must be ≥ 4.
- CH_W, default $clog2(CHANNELS) (minimum 1): width of m_chan.

Ports (one clock; reset is synchronous and active-high):
- bb_clk_in, in, 1: clock.
- rst_h, in, 1: synchronous active-high reset.
- com_in, in, CHANNELS: serial lines, idle high, asynchronous to bb_clk_in.
- parity_mode, in, 2: 00 none, 01 odd, 10 even, 11 treated as none.
- m_valid, out, 1: output word valid.
- m_ready, in, 1: downstream accepts.
- m_data, out, DATA_W: received word.
- m_chan, out, CH_W: source channel.
- m_err, out, 2: bit0 parity error, bit1 framing error.
- overrun, out, CHANNELS: one-cycle pulse per channel when a word is dropped.
- line_busy, out, CHANNELS: lane not in IDLE.

## Operation
- Each lane passes com_in through a 2-flop synchroniser, reset value 1.
- Lane FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - A bit counter runs 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2.
  - Samples are taken at counts HALF-1, HALF and HALF+1. The majority is decided at count HALF+1.
- IDLE:
  - Synchronised line = 0 → START, counter = 0.
  - parity_mode is latched on this transition.
- START:
  - Majority 1 → IDLE (glitch, no output).
  - Otherwise, at count CLKS_PER_BIT-1 → DATA.
- DATA:
  - DATA_W bits, shifted in LSB first.
  - → PARITY if the latched mode is odd or even; → STOP otherwise.
- PARITY:
  - Odd: expected bit = ~^data.
  - Even: expected bit = ^data.
  - Mismatch sets perr.
- STOP, at decision count:
  - The word is delivered to the lane holding register with {ferr, perr}.
  - Stop sampled 1 → IDLE in the same cycle, so the next start is detectable immediately.
  - Stop sampled 0 → ferr = 1 → WAIT_HIGH.
- WAIT_HIGH: → IDLE when the synchronised line = 1.
- Holding register, one word per lane:
  - Load while hold full and not being drained in that cycle: new word dropped, old word kept, overrun pulse.
  - Load in the same cycle as drain: new word stored, no overrun.
- Output stage:
  - One output register with a round-robin arbiter over full holds. Search starts at (last granted + 1) mod CHANNELS.
  - A grant occurs when the output is empty or when m_valid && m_ready. The grant moves the hold into the output register and clears the hold.
  - m_data, m_chan and m_err stay stable while m_valid && !m_ready.
- Reset:
  - All lanes return to IDLE and partial frames are discarded.
  - Holds are emptied.
  - m_valid = 0, m_data = 0, m_chan = 0, m_err = 0, overrun = 0, line_busy = 0, arbiter pointer = CHANNELS-1 (so channel 0 has first priority).

## Timing
- Input synchroniser latency: 2 cycles.
- Stop decision at cycle T → hold full at T+1 → m_valid at T+2 if the output is free. With back-to-back acceptance, throughput is 1 word/cycle.
- Frame length is (DATA_W+3)·CLKS_PER_BIT cycles with parity and (DATA_W+2)·CLKS_PER_BIT without.
- A start bit shorter than HALF+2 cycles is always rejected.
- overrun asserts in cycle T+1 for exactly 1 cycle.

## Structure
- suspi_pkg:
  - lane state enum.
  - PAR_NONE/PAR_ODD/PAR_EVEN constants.
  - ERR_PAR = 0, ERR_FRAME = 1 bit indices.
  - odd_parity function (shared with the SUSPI transmitter).
- Sub-module suspi_rx_lane contains the synchroniser, FSM, shift register and holding register. It is instantiated CHANNELS times.
- The top level contains only the arbiter and output register.

## Test plan
Defaults apply: CHANNELS = 2, DATA_W = 8, CLKS_PER_BIT = 12.
- Frame 0xA5 on ch0, odd mode, parity bit 1 → m_data = A5, m_chan = 0, m_err = 00; m_valid 2 cycles after the mid-stop decision.
- Frame 0x03 on ch1, parity bit inverted → m_err = 01. Same frame in even mode with the correct bit → 00. Mode 00 with a 10-bit frame 0x04 → 04, err 00.
- Frame 0xB6 on ch0 with stop = 0, then line held low 40 cycles → err = 10, line_busy[0] = 1 until the line goes high, no extra words.
- 3-cycle low glitch on ch1 → no m_valid, lane back in IDLE.
- m_ready = 0; simultaneous frames 0x11 ch0 and 0x22 ch1, then 0x33 on ch0 → overrun[0] pulse. With m_ready = 1: 11/ch0 then 22/ch1; 33 never appears.
- rst_h pulsed for 1 cycle mid-DATA on ch0 → all outputs 0. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/suspi_pkg.sv
// Shared SUSPI definitions: lane states, parity modes, error bit indices and
// the parity helper also used by the SUSPI transmitter.
package suspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } lane_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned ERR_PAR   = 0;
  localparam int unsigned ERR_FRAME = 1;

  // Parity bit that makes the total count of ones odd; callers zero-extend
  // their word, which leaves the result unchanged.
  function automatic logic odd_parity(input logic [31:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/suspi_rx_lane.sv
// One SUSPI receive lane: input synchroniser, mid-bit 3-sample majority FSM,
// shift register and a single-word holding register with overrun detection.
module suspi_rx_lane
  import suspi_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 12
) (
  input  logic              bb_clk_in,
  input  logic              rst_h,
  input  logic              com_in,
  input  logic [1:0]        parity_mode,
  input  logic              drain,
  output logic              hold_full,
  output logic [DATA_W-1:0] hold_data,
  output logic [1:0]        hold_err,
  output logic              overrun,
  output logic              line_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  lane_state_t       state_q, state_d;
  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        smp_q;
  logic [IDX_W-1:0]  bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic [1:0]        mode_q;
  logic              perr_q;
  logic              line, maj, dec, last, par_en, exp_par, start_det, load, drop;

  assign line      = sync_q[1];
  assign dec       = (cnt_q == CNT_DEC);
  assign last      = (cnt_q == CNT_LAST);
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & line) | (smp_q[1] & line);
  assign par_en    = (mode_q == PAR_ODD) || (mode_q == PAR_EVEN);
  assign exp_par   = (mode_q == PAR_ODD) ? odd_parity(32'(shreg_q)) : ^shreg_q;
  assign start_det = (state_q == ST_IDLE) && !line;
  assign load      = (state_q == ST_STOP) && dec;
  assign drop      = load && hold_full && !drain;
  assign line_busy = (state_q != ST_IDLE);

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], com_in};
  end

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!line) state_d = ST_START;
      ST_START: begin
        if (dec && maj) state_d = ST_IDLE;
        else if (last)  state_d = ST_DATA;
      end
      ST_DATA:      if (last && bit_q == IDX_LAST) state_d = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (last) state_d = ST_STOP;
      // A good stop returns to IDLE at the decision point so the next start
      // edge can be caught without waiting for the end of the stop bit.
      ST_STOP:      if (dec) state_d = maj ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (line) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) begin
      cnt_q   <= '0;
      smp_q   <= '1;
      bit_q   <= '0;
      shreg_q <= '0;
      mode_q  <= PAR_NONE;
      perr_q  <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_IDLE || last) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_S0) smp_q[0] <= line;
      if (cnt_q == CNT_S1) smp_q[1] <= line;
      if (start_det) begin
        mode_q <= parity_mode;
        perr_q <= 1'b0;
        bit_q  <= '0;
      end
      if (state_q == ST_DATA && dec)  shreg_q <= {maj, shreg_q[DATA_W-1:1]};
      if (state_q == ST_DATA && last) bit_q <= (bit_q == IDX_LAST) ? '0 : bit_q + 1'b1;
      if (state_q == ST_PARITY && dec) perr_q <= maj ^ exp_par;
    end
  end

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_err  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      if (load && !drop) begin
        hold_full           <= 1'b1;
        hold_data           <= shreg_q;
        hold_err[ERR_PAR]   <= perr_q;
        hold_err[ERR_FRAME] <= ~maj;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/suspi_rx_mc.sv
// Multi-channel SUSPI receiver: CHANNELS lanes merged into one valid/ready
// stream by a round-robin arbiter feeding a single output register.
module suspi_rx_mc
  import suspi_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 12,
  parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                bb_clk_in,
  input  logic                rst_h,
  input  logic [CHANNELS-1:0] com_in,
  input  logic [1:0]          parity_mode,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [CH_W-1:0]     m_chan,
  output logic [1:0]          m_err,
  output logic [CHANNELS-1:0] overrun,
  output logic [CHANNELS-1:0] line_busy
);

  logic [CHANNELS-1:0]             hold_full, drain;
  logic [CHANNELS-1:0][DATA_W-1:0] hold_data;
  logic [CHANNELS-1:0][1:0]        hold_err;
  logic [CH_W-1:0]                 ptr_q, sel, idx;
  logic                            found, grant;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    suspi_rx_lane #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_lane (
      .bb_clk_in   (bb_clk_in),
      .rst_h       (rst_h),
      .com_in      (com_in[g]),
      .parity_mode (parity_mode),
      .drain       (drain[g]),
      .hold_full   (hold_full[g]),
      .hold_data   (hold_data[g]),
      .hold_err    (hold_err[g]),
      .overrun     (overrun[g]),
      .line_busy   (line_busy[g])
    );
  end

  // Search from the channel after the last grant so a busy lane cannot starve others.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = CH_W'((32'(ptr_q) + i) % CHANNELS);
      if (!found && hold_full[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    grant = found && (!m_valid || m_ready);
    drain = '0;
    if (grant) drain[sel] = 1'b1;
  end

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_err   <= '0;
      ptr_q   <= CH_W'(CHANNELS - 1);
    end else if (grant) begin
      m_valid <= 1'b1;
      m_data  <= hold_data[sel];
      m_chan  <= sel;
      m_err   <= hold_err[sel];
      ptr_q   <= sel;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_suspi_rx_mc.sv
// Directed plus randomized frames on suspi_rx_mc, checked against a
// bit-counting reference model of the SUSPI frame rules.
module tb_suspi_rx_mc;

  localparam int CPB  = 12;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_h;
  logic [1:0] com_in;
  logic [1:0] parity_mode;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic [0:0] m_chan;
  logic [1:0] m_err;
  logic [1:0] overrun, line_busy;

  suspi_rx_mc #(
    .CHANNELS     (2),
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .bb_clk_in   (clk),
    .rst_h       (rst_h),
    .com_in      (com_in),
    .parity_mode (parity_mode),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_chan      (m_chan),
    .m_err       (m_err),
    .overrun     (overrun),
    .line_busy   (line_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [0:0] chan;
    logic [1:0] err;
    logic [7:0] data;
    int         cyc;
  } word_t;

  word_t      got[$];
  int         cyc = 0;
  int         first_valid = -1;
  int         ov_pulses[2];
  int         ov_high[2];
  int         ov_cyc[2];
  logic [1:0] ov_prev = '0;
  int         n_pass = 0, n_total = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake is recorded just before the edge that completes it.
  task automatic tick();
    if (m_valid && m_ready) got.push_back('{chan: m_chan, err: m_err, data: m_data, cyc: cyc});
    @(posedge clk);
    #1;
    cyc++;
    if (m_valid && first_valid < 0) first_valid = cyc;
    for (int c = 0; c < 2; c++) begin
      if (overrun[c]) begin
        ov_high[c]++;
        if (!ov_prev[c]) begin
          ov_pulses[c]++;
          ov_cyc[c] = cyc;
        end
      end
    end
    ov_prev = overrun;
  endtask

  task automatic idle(input int n);
    com_in = '1;
    repeat (n) tick();
  endtask

  task automatic clr_ov();
    for (int c = 0; c < 2; c++) begin
      ov_pulses[c] = 0;
      ov_high[c]   = 0;
      ov_cyc[c]    = -1;
    end
  endtask

  // Each frame vector is sent bit 0 first; channels with n = 0 stay idle.
  task automatic run_frames(input logic [31:0] f0, input int n0, input logic [31:0] f1, input int n1);
    int          len;
    logic [31:0] s0, s1;
    len = ((n0 > n1) ? n0 : n1) * CPB;
    for (int t = 0; t < len; t++) begin
      s0 = f0 >> (t / CPB);
      s1 = f1 >> (t / CPB);
      com_in[0] = (t / CPB < n0) ? s0[0] : 1'b1;
      com_in[1] = (t / CPB < n1) ? s1[0] : 1'b1;
      tick();
    end
  endtask

  // Reference model: parity judged by counting ones over data plus parity bit.
  function automatic logic good_par(input logic [7:0] d, input logic [1:0] mode);
    int ones;
    ones = $countones(d);
    if (mode == 2'b01) return (ones % 2 == 0);
    return (ones % 2 == 1);
  endfunction

  function automatic logic [1:0] model_err(input logic [7:0] d, input logic [1:0] mode,
                                           input logic pbit, input logic stopb);
    int   tot;
    logic pe;
    tot = $countones(d) + int'(pbit);
    pe  = 1'b0;
    if (mode == 2'b01)      pe = (tot % 2 == 0);
    else if (mode == 2'b10) pe = (tot % 2 != 0);
    return {!stopb, pe};
  endfunction

  function automatic logic [31:0] mk_frame(input logic [7:0] d, input logic [1:0] mode,
                                           input logic pbit, input logic stopb, output int n);
    logic [31:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (mode == 2'b01 || mode == 2'b10) begin
      f[9]  = pbit;
      f[10] = stopb;
      n     = 11;
    end else begin
      f[9] = stopb;
      n    = 10;
    end
    return f;
  endfunction

  function automatic logic [31:0] wval(input logic [0:0] ch, input logic [1:0] err, input logic [7:0] d);
    return {21'b0, ch, err, d};
  endfunction

  function automatic logic [31:0] take_word();
    word_t w;
    if (got.size() == 0) return 32'hFFFF_FFFF;
    w = got.pop_front();
    return wval(w.chan, w.err, w.data);
  endfunction

  function automatic int got_cyc(input int i);
    if (got.size() > i) return got[i].cyc;
    return -100;
  endfunction

  task automatic pulse_reset();
    rst_h  = 1'b1;
    com_in = '1;
    tick();
    rst_h  = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_valid"}, 32'(m_valid), 0);
    check({pfx, "_data"}, 32'(m_data), 0);
    check({pfx, "_chan"}, 32'(m_chan), 0);
    check({pfx, "_err"}, 32'(m_err), 0);
    check({pfx, "_overrun"}, 32'(overrun), 0);
    check({pfx, "_busy"}, 32'(line_busy), 0);
  endtask

  initial begin
    logic [31:0] f, g;
    int          n, m, k0;
    logic [7:0]  d;
    logic [1:0]  md;
    logic        pb, sb;
    logic [0:0]  ch;

    rst_h = 1'b1; com_in = '1; m_ready = 1'b1; parity_mode = 2'b00;
    clr_ov();
    repeat (3) tick();
    check_zero("reset");
    rst_h = 1'b0;
    idle(4);

    // 0xA5, odd mode, correct parity bit; timing of m_valid from the start edge.
    parity_mode = 2'b01;
    pb = good_par(8'hA5, 2'b01);
    f = mk_frame(8'hA5, 2'b01, pb, 1'b1, n);
    first_valid = -1; k0 = cyc;
    run_frames(f, n, '1, 0);
    idle(20);
    check("a5_count", 32'(got.size()), 1);
    check("a5_word", take_word(), wval(1'b0, model_err(8'hA5, 2'b01, pb, 1'b1), 8'hA5));
    check("a5_latency", 32'(first_valid), 32'(k0 + (n - 1) * CPB + HALF + 6));

    // 0x03 on ch1: odd with flipped parity, even with correct parity, none.
    pb = !good_par(8'h03, 2'b01);
    f = mk_frame(8'h03, 2'b01, pb, 1'b1, n);
    run_frames('1, 0, f, n); idle(20);
    check("odd_bad_count", 32'(got.size()), 1);
    check("odd_bad_word", take_word(), wval(1'b1, model_err(8'h03, 2'b01, pb, 1'b1), 8'h03));
    parity_mode = 2'b10;
    pb = good_par(8'h03, 2'b10);
    f = mk_frame(8'h03, 2'b10, pb, 1'b1, n);
    run_frames('1, 0, f, n); idle(20);
    check("even_ok_count", 32'(got.size()), 1);
    check("even_ok_word", take_word(), wval(1'b1, 2'b00, 8'h03));
    parity_mode = 2'b00;
    f = mk_frame(8'h04, 2'b00, 1'b0, 1'b1, n);
    run_frames('1, 0, f, n); idle(20);
    check("none_count", 32'(got.size()), 1);
    check("none_word", take_word(), wval(1'b1, 2'b00, 8'h04));

    // 0xB6 with a low stop bit and the line held low afterwards.
    parity_mode = 2'b10;
    pb = good_par(8'hB6, 2'b10);
    f = mk_frame(8'hB6, 2'b10, pb, 1'b0, n);
    f[13:11] = 3'b000;
    run_frames(f, n + 3, '1, 0);
    check("ferr_busy_low", 32'(line_busy), 32'b01);
    idle(30);
    check("ferr_busy_high", 32'(line_busy), 0);
    check("ferr_count", 32'(got.size()), 1);
    check("ferr_word", take_word(), wval(1'b0, model_err(8'hB6, 2'b10, pb, 1'b0), 8'hB6));

    // 3-cycle glitch on ch1.
    com_in = 2'b01;
    repeat (3) tick();
    com_in = '1;
    tick();
    check("glitch_seen", 32'(line_busy), 32'b10);
    idle(40);
    check("glitch_count", 32'(got.size()), 0);
    check("glitch_valid", 32'(m_valid), 0);
    check("glitch_busy", 32'(line_busy), 0);

    // Output blocked: filler on ch1, then 0x11/0x22 together, then 0x33 overruns ch0.
    pulse_reset();
    m_ready = 1'b0; parity_mode = 2'b00;
    clr_ov();
    f = mk_frame(8'h5C, 2'b00, 1'b0, 1'b1, n);
    run_frames('1, 0, f, n); idle(20);
    f = mk_frame(8'h11, 2'b00, 1'b0, 1'b1, n);
    g = mk_frame(8'h22, 2'b00, 1'b0, 1'b1, m);
    run_frames(f, n, g, m); idle(20);
    f = mk_frame(8'h33, 2'b00, 1'b0, 1'b1, n);
    k0 = cyc;
    run_frames(f, n, '1, 0); idle(20);
    check("ov0_pulses", 32'(ov_pulses[0]), 1);
    check("ov0_width", 32'(ov_high[0]), 1);
    check("ov1_pulses", 32'(ov_pulses[1]), 0);
    check("ov0_cycle", 32'(ov_cyc[0]), 32'(k0 + (n - 1) * CPB + HALF + 5));
    check("stall_valid", 32'(m_valid), 1);
    check("stall_word", wval(m_chan, m_err, m_data), wval(1'b1, 2'b00, 8'h5C));
    m_ready = 1'b1;
    idle(10);
    check("drain_count", 32'(got.size()), 3);
    check("drain_gap1", 32'(got_cyc(1) - got_cyc(0)), 1);
    check("drain_gap2", 32'(got_cyc(2) - got_cyc(1)), 1);
    check("drain_w0", take_word(), wval(1'b1, 2'b00, 8'h5C));
    check("drain_w1", take_word(), wval(1'b0, 2'b00, 8'h11));
    check("drain_w2", take_word(), wval(1'b1, 2'b00, 8'h22));

    // Reset mid-DATA with a word waiting in the output register.
    m_ready = 1'b0;
    f = mk_frame(8'h7E, 2'b00, 1'b0, 1'b1, n);
    run_frames(f, n, '1, 0); idle(20);
    check("pre_rst_valid", 32'(m_valid), 1);
    check("pre_rst_data", 32'(m_data), 32'h7E);
    f = mk_frame(8'h96, 2'b00, 1'b0, 1'b1, n);
    run_frames(f, 4, '1, 0);
    check("mid_data_busy", 32'(line_busy), 32'b01);
    pulse_reset();
    check_zero("midrst");
    m_ready = 1'b1;
    idle(150);
    check("midrst_count", 32'(got.size()), 0);
    parity_mode = 2'b01;
    pb = good_par(8'h5A, 2'b01);
    f = mk_frame(8'h5A, 2'b01, pb, 1'b1, n);
    run_frames(f, n, '1, 0); idle(20);
    check("post_rst_count", 32'(got.size()), 1);
    check("post_rst_word", take_word(), wval(1'b0, 2'b00, 8'h5A));

    // Randomized single frames against the model.
    for (int i = 0; i < 8; i++) begin
      ch = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      md = 2'($urandom_range(0, 3));
      pb = good_par(d, md) ^ 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      parity_mode = md;
      f = mk_frame(d, md, pb, sb, n);
      first_valid = -1; k0 = cyc;
      if (ch == 1'b0) run_frames(f, n, '1, 0);
      else            run_frames('1, 0, f, n);
      idle(25);
      check($sformatf("rnd%0d_count", i), 32'(got.size()), 1);
      check($sformatf("rnd%0d_word", i), take_word(), wval(ch, model_err(d, md, pb, sb), d));
      check($sformatf("rnd%0d_latency", i), 32'(first_valid), 32'(k0 + (n - 1) * CPB + HALF + 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
